// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Bit timing comes from an internal counter loaded with the BC-selected divisor.
module uart_tx #(
  parameter int unsigned DIV_DEF = 434,
  parameter int unsigned DIV_1   = 217,
  parameter int unsigned DIV_2   = 109,
  parameter int unsigned DIV_3   = 72,
  parameter int unsigned DIV_4   = 36,
  parameter int unsigned CNT_W   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] BC,
  input  logic       PE,
  input  logic       PT,
  input  logic [7:0] Tx_data,
  input  logic       Tx_start,
  output logic       Tx,
  output logic       Tx_busy,
  output logic       Tx_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] div_sel(input logic [2:0] bc);
    logic [CNT_W-1:0] d;
    case (bc)
      3'b001:  d = CNT_W'(DIV_1);
      3'b010:  d = CNT_W'(DIV_2);
      3'b011:  d = CNT_W'(DIV_3);
      3'b100:  d = CNT_W'(DIV_4);
      default: d = CNT_W'(DIV_DEF);
    endcase
    return d;
  endfunction

  // PT=1 makes the total count of ones (data plus parity) odd.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_div, w_div_nx;
  logic [2:0]       r_idx, w_idx_nx;
  logic [7:0]       r_data, w_data_nx;
  logic             r_pe, w_pe_nx;
  logic             r_pt, w_pt_nx;
  logic             r_tx, w_tx_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;

  logic             w_bit_end;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [2:0]       w_idx_inc;

  assign w_bit_end = (r_cnt == (r_div - CNT_W'(1)));
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_idx_inc = r_idx + 3'd1;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_div_nx   = r_div;
    w_idx_nx   = r_idx;
    w_data_nx  = r_data;
    w_pe_nx    = r_pe;
    w_pt_nx    = r_pt;
    w_tx_nx    = r_tx;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nx   = 1'b1;
        w_busy_nx = 1'b0;
        if (Tx_start) begin
          w_data_nx  = Tx_data;
          w_div_nx   = div_sel(BC);
          w_pe_nx    = PE;
          w_pt_nx    = PT;
          w_tx_nx    = 1'b0;
          w_busy_nx  = 1'b1;
          w_cnt_nx   = '0;
          w_idx_nx   = 3'd0;
          w_state_nx = S_START;
        end else begin
          w_cnt_nx = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_idx_nx   = 3'd0;
          w_tx_nx    = r_data[0];
          w_state_nx = S_DATA;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nx = '0;
          if (r_idx == 3'd7) begin
            if (r_pe) begin
              w_tx_nx    = parity_bit(r_data, r_pt);
              w_state_nx = S_PARITY;
            end else begin
              w_tx_nx    = 1'b1;
              w_state_nx = S_STOP;
            end
          end else begin
            w_idx_nx = w_idx_inc;
            w_tx_nx  = r_data[w_idx_inc];
          end
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_tx_nx    = 1'b1;
          w_state_nx = S_STOP;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_idx_nx   = 3'd0;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_idx_nx   = 3'd0;
        w_tx_nx    = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame with the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_idx   <= 3'd0;
      r_data  <= 8'd0;
      r_pe    <= 1'b0;
      r_pt    <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_div   <= w_div_nx;
      r_idx   <= w_idx_nx;
      r_data  <= w_data_nx;
      r_pe    <= w_pe_nx;
      r_pt    <= w_pt_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign Tx      = r_tx;
  assign Tx_busy = r_busy;
  assign Tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: every cycle of each frame is compared against
// a line waveform computed from the frame's bit list and bit period.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] BC;
  logic       PE;
  logic       PT;
  logic [7:0] Tx_data;
  logic       Tx_start;
  logic       Tx;
  logic       Tx_busy;
  logic       Tx_done;

  int errors = 0;
  int checks = 0;

  uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .BC       (BC),
    .PE       (PE),
    .PT       (PT),
    .Tx_data  (Tx_data),
    .Tx_start (Tx_start),
    .Tx       (Tx),
    .Tx_busy  (Tx_busy),
    .Tx_done  (Tx_done)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h ({Tx,busy,done})", tag, $time, got, exp);
    end
  endtask

  function automatic int bit_period(input logic [2:0] bc);
    case (bc)
      3'b001:  return 217;
      3'b010:  return 109;
      3'b011:  return 72;
      3'b100:  return 36;
      default: return 434;
    endcase
  endfunction

  function automatic logic [31:0] line_state();
    return {29'd0, Tx, Tx_busy, Tx_done};
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle", line_state(), 32'd4);
    end
  endtask

  // Called at a negedge; requests a frame and checks every cycle up to the Tx_done cycle.
  // abort_c > 0 asserts rst at that cycle instead of finishing the frame.
  task automatic send_frame(input logic [2:0] bc, input logic pe, input logic pt,
                            input logic [7:0] data, input bit hold, input bit disturb,
                            input int abort_c);
    int          d;
    int          nb;
    int          last;
    int          ones;
    logic [10:0] bits;
    logic [2:0]  exp;
    d    = bit_period(bc);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    ones = $countones(data);
    nb   = 9;
    if (pe) begin
      bits[9] = (((ones + int'(pt)) % 2) == 1);
      nb = 10;
    end
    bits[nb] = 1'b1;
    nb   = nb + 1;
    last = nb * d + 1;
    BC = bc; PE = pe; PT = pt; Tx_data = data; Tx_start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == abort_c) begin
        rst = 1'b1;
        #1;
        check_val("abort", line_state(), 32'd4);
        return;
      end
      if (c <= nb * d) exp = {bits[(c-1)/d], 2'b10};
      else             exp = 3'b101;
      check_val("frame", line_state(), {29'd0, exp});
      if (!hold) Tx_start = 1'b0;
      if (disturb && c < last) begin
        if ($urandom_range(0, 15) == 0) begin
          Tx_start = 1'($urandom);
          Tx_data  = 8'($urandom);
          BC       = 3'($urandom);
          PE       = 1'($urandom);
          PT       = 1'($urandom);
        end
        if (c == 2 * d) begin
          Tx_start = 1'b1;
          Tx_data  = 8'hFF;
          BC       = 3'b001;
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; BC = 3'b000; PE = 1'b0; PT = 1'b0; Tx_data = 8'h00; Tx_start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset", line_state(), 32'd4);
    rst = 1'b0;
    idle_check(2);

    send_frame(3'b000, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 0);
    idle_check(3);

    send_frame(3'b100, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 0);
    idle_check(2);
    send_frame(3'b100, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 0);
    idle_check(2);

    send_frame(3'b011, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 0);
    Tx_start = 1'b0;
    idle_check(20);

    send_frame(3'b001, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 0);
    send_frame(3'b001, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 0);
    Tx_start = 1'b0;
    idle_check(5);

    send_frame(3'b010, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 5 * 109 + 40);
    Tx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("in_reset", line_state(), 32'd4);
    end
    rst = 1'b0;
    idle_check(3);
    send_frame(3'b010, 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 0);
    idle_check(2);

    send_frame(3'b111, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 0);
    idle_check(2);

    for (int k = 0; k < 6; k++) begin
      send_frame(3'($urandom_range(1, 4)), 1'($urandom), 1'($urandom), 8'($urandom),
                 1'b0, 1'b1, 0);
      Tx_start = 1'b0;
      idle_check($urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter. It is the transmit-side counterpart to the receive path clocked by BaudControl's Rx_clk.
- Serialises one 8-bit word per frame: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Uses the same 3-bit baud select (BC) and divisor table as BaudControl.
- Runs on the 50 MHz system clock with an internal bit-period counter, not a derived clock.

Parameters:
DIV_DEF, 434, clk cycles per bit for BC=000 and for unlisted codes (101/110/111); 115200 baud at 50 MHz
DIV_1, 217, cycles per bit for BC=001
DIV_2, 109, cycles per bit for BC=010
DIV_3, 72, cycles per bit for BC=011
DIV_4, 36, cycles per bit for BC=100
CNT_W, 9, bit-period counter width; must hold DIV_DEF-1

Ports:
clk  input  1  50 MHz system clock, rising edge
rst  input  1  asynchronous, active-high reset
BC  input  3  baud select, same encoding as BaudControl
PE  input  1  parity enable
PT  input  1  parity type: 0 even, 1 odd
Tx_data  input  8  word to send
Tx_start  input  1  request; sampled only in IDLE
Tx  output  1  serial line, idle high
Tx_busy  output  1  high from start acceptance until return to IDLE
Tx_done  output  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset (async assert, sync release): state=IDLE, Tx=1, Tx_busy=0, Tx_done=0, counter=0, bit index=0. Reset mid-frame aborts immediately; Tx returns high with no partial stop bit.
- All outputs are registered.
- States: IDLE -> START -> DATA -> (PARITY if PE latched) -> STOP -> IDLE.
- IDLE: Tx=1, Tx_busy=0. On a rising edge with Tx_start=1, in the same edge:
  - latch Tx_data, BC-derived divisor D, PE and PT;
  - set Tx=0, Tx_busy=1, counter=0, state=START.
  - Tx therefore falls one edge after Tx_start is sampled.
- Bit timing: each bit holds Tx for exactly D clk cycles. Counter runs 0..D-1; at D-1 it wraps to 0 and the next bit's value is driven on the same edge.
- DATA: bits Tx_data[0]..[7], index 0..7. After bit 7 go to PARITY if PE else STOP.
- PARITY: Tx = ^Tx_data XOR PT, so the total count of ones across data plus parity is even when PT=0 and odd when PT=1.
- STOP: Tx=1 for D cycles. On the final edge: state=IDLE, Tx_busy=0, Tx_done=1 for exactly one cycle.
- Frame length is 10*D cycles, or 11*D with PE.
- Tx_start while busy: ignored, no queuing.
- Tx_start high on the cycle Tx_done is high: state is already IDLE, so it is accepted. This gives a back-to-back frame with no idle gap beyond the full stop bit.
- Changes to BC, PE, PT or Tx_data mid-frame have no effect until the next accepted start.
- Tx_start held high continuously: frames repeat back-to-back.

Test Plan:
- Reset, BC=000, PE=0, Tx_data=0xA5, pulse Tx_start 1 cycle:
  - Tx low for 434 cycles, then 1,0,1,0,0,1,0,1 at 434 cycles each, then high 434.
  - Tx_done pulses exactly 4340 cycles after Tx falls; Tx_busy low on the same edge.
- BC=100, PE=1, PT=0, Tx_data=0x07 -> 36-cycle bits, parity bit=1, frame 396 cycles. Repeat with PT=1 -> parity bit=0.
- BC=011, Tx_data=0x3C; during DATA pulse Tx_start with Tx_data=0xFF and change BC to 001:
  - frame still 72-cycle bits carrying 0x3C;
  - no second frame starts;
  - Tx_busy stays high throughout.
- BC=001, hold Tx_start high across two frames (0x55 then 0xAA) -> second start bit begins the cycle after Tx_done, 217 cycles per bit, no extra idle.
- BC=010; assert rst for 3 cycles during data bit 4 -> Tx=1, Tx_busy=0, Tx_done stays 0. After release, a new Tx_start sends a full correct frame.
- BC=111 (unlisted code) -> bit period 434 cycles.
